// File: rtl/maxpool_row_stage_pkg.sv
// Shared sizes, FSM encodings and channel layout for the 2x2 max-pool row stage.
// Pixels are packed {a,b,c}, each channel an unsigned BD-bit value.
package maxpool_row_stage_pkg;

  localparam int BD       = 18;
  localparam int AW       = 11;
  localparam int INWIDTH  = 1918;
  localparam int OUTWIDTH = INWIDTH / 2;
  localparam int OUTROWS  = 539;
  localparam int PW       = 3 * BD;

  localparam int CH_A_HI = 3 * BD - 1;
  localparam int CH_A_LO = 2 * BD;
  localparam int CH_B_HI = 2 * BD - 1;
  localparam int CH_B_LO = BD;
  localparam int CH_C_HI = BD - 1;
  localparam int CH_C_LO = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_COL = AW'(INWIDTH - 1);

endpackage

// File: rtl/maxpool_row_stage_max3.sv
// Per-channel unsigned max of two packed {a,b,c} pixels; purely combinational.
module pool_max3
  import maxpool_row_stage_pkg::*;
(
  input  logic [PW-1:0] x,
  input  logic [PW-1:0] y,
  output logic [PW-1:0] m
);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      assign m[gi*BD +: BD] = (x[gi*BD +: BD] >= y[gi*BD +: BD]) ? x[gi*BD +: BD]
                                                                 : y[gi*BD +: BD];
    end
  endgenerate

endmodule

// File: rtl/maxpool_row_stage.sv
// Reads one pair of conv output rows, writes the 2x2-max pooled row.
// One start may queue behind the active row; further starts are dropped and flagged.
module maxpool_row_stage
  import maxpool_row_stage_pkg::*;
#(
  parameter int N_ROWS = OUTROWS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          bank,
  input  logic [PW-1:0] row0_q,
  input  logic [PW-1:0] row1_q,
  output logic          rden,
  output logic          rd_bank,
  output logic [AW-1:0] rdaddr,
  output logic          wren,
  output logic [AW-1:0] wraddr,
  output logic [PW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          frame_done,
  output logic          overrun
);

  localparam int RCW = $clog2(N_ROWS + 1);
  localparam logic [RCW-1:0] LAST_ROW = RCW'(N_ROWS - 1);

  logic [1:0]     state_reg;
  logic [AW-1:0]  col_reg;
  logic           drain_reg;
  logic           bank_reg;
  logic           pend_reg;
  logic           pend_bank_reg;
  logic           overrun_reg;
  logic [RCW-1:0] row_cnt_reg;

  logic           vld_reg;
  logic [AW-1:0]  vcol_reg;
  logic [PW-1:0]  hold_reg;
  logic           wren_reg;
  logic [AW-1:0]  wraddr_reg;
  logic [PW-1:0]  wdata_reg;

  logic [PW-1:0]  vmax;
  logic [PW-1:0]  hmax;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      col_reg     <= '0;
      drain_reg   <= 1'b0;
      bank_reg    <= 1'b0;
      row_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_READ;
            bank_reg  <= bank;
            col_reg   <= '0;
          end
        end
        ST_READ: begin
          if (col_reg == LAST_COL) begin
            state_reg <= ST_DRAIN;
            col_reg   <= '0;
            drain_reg <= 1'b0;
          end else begin
            col_reg <= col_reg + AW'(1);
          end
        end
        ST_DRAIN: begin
          drain_reg <= 1'b1;
          if (drain_reg) state_reg <= ST_DONE;
        end
        default: begin
          row_cnt_reg <= (row_cnt_reg == LAST_ROW) ? '0 : row_cnt_reg + RCW'(1);
          // A start arriving in DONE with nothing queued launches straight away.
          if (pend_reg || start) begin
            state_reg <= ST_READ;
            bank_reg  <= pend_reg ? pend_bank_reg : bank;
            col_reg   <= '0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_reg      <= 1'b0;
      pend_bank_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else if (state_reg == ST_DONE) begin
      pend_reg <= 1'b0;
      if (start && pend_reg) overrun_reg <= 1'b1;
    end else if (state_reg != ST_IDLE && start) begin
      if (pend_reg) begin
        overrun_reg <= 1'b1;
      end else begin
        pend_reg      <= 1'b1;
        pend_bank_reg <= bank;
      end
    end
  end

  pool_max3 u_vmax (
    .x (row0_q),
    .y (row1_q),
    .m (vmax)
  );

  pool_max3 u_hmax (
    .x (hold_reg),
    .y (vmax),
    .m (hmax)
  );

  // Read data lags rdaddr by one cycle; vld/vcol track which column it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_reg    <= 1'b0;
      vcol_reg   <= '0;
      hold_reg   <= '0;
      wren_reg   <= 1'b0;
      wraddr_reg <= '0;
      wdata_reg  <= '0;
    end else begin
      vld_reg  <= rden;
      vcol_reg <= col_reg;
      wren_reg <= 1'b0;
      if (vld_reg) begin
        if (!vcol_reg[0]) begin
          hold_reg <= vmax;
        end else begin
          wdata_reg  <= hmax;
          wraddr_reg <= vcol_reg >> 1;
          wren_reg   <= 1'b1;
        end
      end
    end
  end

  assign rden       = (state_reg == ST_READ);
  assign rd_bank    = bank_reg;
  assign rdaddr     = col_reg;
  assign wren       = wren_reg;
  assign wraddr     = wraddr_reg;
  assign wdata      = wdata_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign frame_done = done && (row_cnt_reg == LAST_ROW);
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_maxpool_row_stage.sv
// Bench for maxpool_row_stage: two-bank row-buffer model, write scoreboard,
// constant spot-check table and hand-written queue/reset/frame sequences.
module tb_maxpool_row_stage;
  import maxpool_row_stage_pkg::*;

  localparam int FR = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          bank = 1'b0;
  logic [PW-1:0] row0_q = '0;
  logic [PW-1:0] row1_q = '0;
  logic          rden, rd_bank, wren, busy, done, frame_done, overrun;
  logic [AW-1:0] rdaddr, wraddr;
  logic [PW-1:0] wdata;

  maxpool_row_stage #(.N_ROWS(FR)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bank       (bank),
    .row0_q     (row0_q),
    .row1_q     (row1_q),
    .rden       (rden),
    .rd_bank    (rd_bank),
    .rdaddr     (rdaddr),
    .wren       (wren),
    .wraddr     (wraddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] mem0 [2][INWIDTH];
  logic [PW-1:0] mem1 [2][INWIDTH];
  logic [PW-1:0] cap  [OUTWIDTH];

  always @(posedge clk) begin
    if (rden) begin
      row0_q <= mem0[rd_bank][rdaddr];
      row1_q <= mem1[rd_bank][rdaddr];
    end
  end

  typedef struct { int addr; logic [PW-1:0] data; } sb_t;
  sb_t sb_q[$];

  typedef struct { int pat; int k; logic [PW-1:0] exp; } vec_t;
  vec_t tbl[6];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pk(input int a, input int b, input int c);
    logic [BD-1:0] av, bv, cv;
    av = BD'(a); bv = BD'(b); cv = BD'(c);
    return {av, bv, cv};
  endfunction

  function automatic logic [PW-1:0] expect_px(input int bk, input int k);
    logic [PW-1:0] r;
    logic [BD-1:0] v [4];
    logic [BD-1:0] best;
    r = '0;
    for (int ch = 0; ch < 3; ch++) begin
      v[0] = mem0[bk][2*k][ch*BD +: BD];
      v[1] = mem1[bk][2*k][ch*BD +: BD];
      v[2] = mem0[bk][2*k+1][ch*BD +: BD];
      v[3] = mem1[bk][2*k+1][ch*BD +: BD];
      best = v[0];
      for (int i = 1; i < 4; i++) if (v[i] > best) best = v[i];
      r[ch*BD +: BD] = best;
    end
    return r;
  endfunction

  task automatic fill(input int bk, input int pat);
    for (int j = 0; j < INWIDTH; j++) begin
      logic [BD-1:0] a0, a1, b0, b1, c0, c1;
      case (pat)
        0: begin
          a0 = BD'(j); a1 = BD'(2*j); b0 = '0; b1 = '0; c0 = '0; c1 = '0;
        end
        1: begin
          a0 = (j % 2 == 0) ? BD'(40000 + j) : BD'(j);
          a1 = (j == 5) ? '1 : BD'(j / 2);
          b0 = BD'(j / 3);
          b1 = (j % 2 == 1) ? BD'(262143 - j) : '0;
          c0 = BD'(5); c1 = BD'(5);
        end
        default: begin
          a0 = BD'($urandom); a1 = BD'($urandom); b0 = BD'($urandom);
          b1 = BD'($urandom); c0 = BD'($urandom); c1 = BD'($urandom);
        end
      endcase
      mem0[bk][j] = {a0, b0, c0};
      mem1[bk][j] = {a1, b1, c1};
    end
  endtask

  task automatic push_row(input int bk);
    for (int k = 0; k < OUTWIDTH; k++) sb_q.push_back('{addr: k, data: expect_px(bk, k)});
  endtask

  // Advance one cycle to the next falling edge and score any write seen there.
  task automatic cycle();
    sb_t e;
    @(negedge clk);
    if (wren) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_wren", {53'd0, wren}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_wdata", wdata, e.data);
        check("sb_wraddr", wraddr, e.addr);
        cap[wraddr] = wdata;
      end
    end
  endtask

  task automatic run_row(input logic b);
    int first_wr, last_wr, nwr, done_cyc;
    first_wr = -1; last_wr = -1; nwr = 0; done_cyc = -1;
    push_row(b);
    start = 1'b1; bank = b;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 2100 && done_cyc < 0; c++) begin
      if (c == 0) begin
        check("row_start_rden", rden, 1);
        check("row_start_rdaddr", rdaddr, 0);
        check("row_start_bank", rd_bank, b);
      end
      if (wren) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        nwr++;
      end
      if (done) done_cyc = c;
      cycle();
    end
    check("first_wr_cycle", first_wr, 3);
    check("last_wr_cycle", last_wr, 1919);
    check("wr_count", nwr, OUTWIDTH);
    check("done_cycle", done_cyc, 1920);
    check("idle_after_row", busy, 0);
    check("sb_empty", sb_q.size(), 0);
  endtask

  initial begin
    int last_pat, bad, d1, d2, nd, nf, fd_row, d_last;

    tbl[0] = '{pat: 0, k: 0,   exp: pk(2, 0, 0)};
    tbl[1] = '{pat: 0, k: 479, exp: pk(1918, 0, 0)};
    tbl[2] = '{pat: 0, k: 958, exp: pk(3834, 0, 0)};
    tbl[3] = '{pat: 1, k: 0,   exp: pk(40000, 262142, 5)};
    tbl[4] = '{pat: 1, k: 2,   exp: pk(262143, 262138, 5)};
    tbl[5] = '{pat: 1, k: 958, exp: pk(41916, 260226, 5)};

    fill(0, 0);
    fill(1, 2);

    // Reset state and quiet idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cycle();
    check("rst_rden", rden, 0);
    check("rst_wren", wren, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rdaddr", rdaddr, 0);
    check("rst_wraddr", wraddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_rd_bank", rd_bank, 0);
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (rden || wren || busy) bad++;
      cycle();
    end
    check("idle_no_activity", bad, 0);

    // Table-driven spot checks on the captured pooled row
    last_pat = -1;
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].pat != last_pat) begin
        fill(0, tbl[i].pat);
        run_row(1'b0);
        last_pat = tbl[i].pat;
      end
      $display("vector %0d: pattern %0d col %0d got 0x%0h", i, tbl[i].pat, tbl[i].k, cap[tbl[i].k]);
      check("tbl_wdata", cap[tbl[i].k], tbl[i].exp);
    end

    // Random data from bank 1
    run_row(1'b1);

    // Queueing: second start queued with bank 1, third dropped
    fill(0, 0);
    push_row(0);
    push_row(1);
    start = 1'b1; bank = 1'b0;
    cycle();
    start = 1'b0;
    d1 = -1; d2 = -1;
    for (int c = 0; c < 4000 && d2 < 0; c++) begin
      if (c == 500) begin start = 1'b1; bank = 1'b1; end
      if (c == 501 || c == 601) start = 1'b0;
      if (c == 600) begin start = 1'b1; bank = 1'b0; end
      if (c == 599) check("q_overrun_before", overrun, 0);
      if (c == 602) check("q_overrun_after", overrun, 1);
      if (c == 1500) check("q_rd_bank_row1", rd_bank, 0);
      if (c == 1921) begin
        check("q_row2_rden", rden, 1);
        check("q_row2_rdaddr", rdaddr, 0);
        check("q_row2_bank", rd_bank, 1);
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else d2 = c;
      end
      cycle();
    end
    check("q_done1_cycle", d1, 1920);
    check("q_done2_cycle", d2, 3841);
    check("q_idle_after", busy, 0);
    check("q_overrun_sticky", overrun, 1);
    check("q_sb_empty", sb_q.size(), 0);

    // Reset in the middle of a row
    fill(0, 2);
    push_row(0);
    start = 1'b1; bank = 1'b0;
    cycle();
    start = 1'b0;
    for (int c = 0; c < 1000; c++) cycle();
    reset = 1'b1;
    #1;
    check("mid_rst_wren", wren, 0);
    check("mid_rst_rden", rden, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdaddr", rdaddr, 0);
    check("mid_rst_wdata", wdata, 0);
    check("mid_rst_wraddr", wraddr, 0);
    check("mid_rst_overrun", overrun, 0);
    sb_q.delete();
    repeat (3) cycle();
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (wren || busy) bad++;
      cycle();
    end
    check("post_rst_quiet", bad, 0);
    run_row(1'b0);

    // Back-to-back frame of FR rows: starts in DONE, then one queued start
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    fill(0, 2);
    for (int r = 0; r < FR; r++) push_row(0);
    start = 1'b1; bank = 1'b0;
    cycle();
    nd = 0; nf = 0; fd_row = -1; d_last = -1;
    for (int c = 0; c < FR * 1921 + 50 && nd < FR; c++) begin
      start = 1'b0;
      if (done) begin
        nd++;
        d_last = c;
        if (frame_done) begin nf++; fd_row = nd; end
        if (nd <= 2) start = 1'b1;
      end else begin
        if (frame_done) nf++;
        if (nd == 2 && rden && rdaddr == 100) start = 1'b1;
      end
      cycle();
    end
    start = 1'b0;
    check("frame_rows_done", nd, FR);
    check("frame_done_count", nf, 1);
    check("frame_done_row", fd_row, FR);
    check("frame_last_done_cycle", d_last, FR * 1921 - 1);
    check("frame_row_cnt_wrapped", dut.row_cnt_reg, 0);
    check("frame_sb_empty", sb_q.size(), 0);
    check("frame_no_overrun", overrun, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
